// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory access blocks: width and
// error encodings, the store writer state encoding and a width helper.
package mem_pkg;

    // Request width encodings as seen on req_width
    localparam logic [1:0] WIDTH_BYTE    = 2'd0;
    localparam logic [1:0] WIDTH_HALF    = 2'd1;
    localparam logic [1:0] WIDTH_WORD    = 2'd2;
    localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

    // Error codes reported alongside the error pulse
    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_RANGE      = 2'b10;
    localparam logic [1:0] ERR_WIDTH      = 2'b11;

    // Store writer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Number of bytes moved by a request of the given width; zero for the
    // illegal encoding so that it can never look like a real transfer.
    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        logic [2:0] count;
        case (width)
            WIDTH_BYTE: count = 3'd1;
            WIDTH_HALF: count = 3'd2;
            WIDTH_WORD: count = 3'd4;
            default:    count = 3'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/memory_store_writer_if.sv
// Store request channel from the CPU load/store path together with the
// byte-wide memory write port and the completion/error status it produces.
interface memory_store_writer_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [1:0]  req_width;

    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;

    logic        done;
    logic        error;
    logic [1:0]  error_code;

    // Request issuer side: drives the request, observes everything else
    modport master (
        output req_valid,
        output req_address,
        output req_data,
        output req_width,
        input  req_ready,
        input  mem_address,
        input  mem_write_data,
        input  mem_write_enable,
        input  done,
        input  error,
        input  error_code
    );

    // Store writer side: consumes the request, drives the memory port
    modport slave (
        input  req_valid,
        input  req_address,
        input  req_data,
        input  req_width,
        output req_ready,
        output mem_address,
        output mem_write_data,
        output mem_write_enable,
        output done,
        output error,
        output error_code
    );

endinterface

// File: rtl/store_request_check.sv
// Combinational legality check of a memory request: width, alignment and
// address range against a memory of depth 32-bit words. Shared with the load
// side so both directions reject exactly the same requests.
module store_request_check
    import mem_pkg::*;
#(
    parameter int unsigned depth = 512
) (
    input  logic [31:0] address,
    input  logic [1:0]  width,
    output logic        legal,
    output logic [1:0]  error_code,
    output logic [2:0]  byte_count
);

    // Byte capacity held in 33 bits so the end-of-request sum never wraps
    localparam logic [32:0] CAPACITY = 33'(depth) << 2;

    logic [32:0] end_address;
    logic        misaligned;

    assign byte_count  = width_to_bytes(width);
    assign end_address = {1'b0, address} + {30'b0, byte_count};

    // A half must start on an even byte, a word on a multiple of four
    always_comb begin
        misaligned = 1'b0;
        case (width)
            WIDTH_HALF: misaligned = address[0];
            WIDTH_WORD: misaligned = |address[1:0];
            default:    misaligned = 1'b0;
        endcase
    end

    // Width beats alignment beats range when several problems coexist
    always_comb begin
        error_code = ERR_NONE;
        if (width == WIDTH_ILLEGAL) begin
            error_code = ERR_WIDTH;
        end else if (misaligned) begin
            error_code = ERR_MISALIGNED;
        end else if (end_address > CAPACITY) begin
            error_code = ERR_RANGE;
        end
        legal = (error_code == ERR_NONE);
    end

endmodule

// File: rtl/memory_store_writer.sv
// Accepts one 32-bit store request and serialises it into little-endian
// single-byte writes, one per clock, on a byte-wide memory write port.
// Illegal requests are rejected before any write with an error pulse.
module memory_store_writer
    import mem_pkg::*;
#(
    parameter int unsigned depth = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_store_writer_if.slave  bus
);

    state_t      state;
    logic [31:0] mem_address_q;
    logic [7:0]  mem_write_data_q;
    logic        mem_write_enable_q;
    logic        done_q;
    logic        error_q;
    logic [1:0]  error_code_q;

    // Remaining store bytes, lowest pending byte in [7:0]
    logic [31:0] data_shift;
    // Bytes still to be written after the one currently on the port
    logic [2:0]  bytes_left;

    logic        check_legal;
    logic [1:0]  check_code;
    logic [2:0]  check_bytes;

    store_request_check #(
        .depth (depth)
    ) u_check (
        .address    (bus.req_address),
        .width      (bus.req_width),
        .legal      (check_legal),
        .error_code (check_code),
        .byte_count (check_bytes)
    );

    assign bus.req_ready        = (state == ST_IDLE);
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;
    assign bus.error_code       = error_code_q;

    // Control FSM: byte 0 is put on the port at the accept edge so it is
    // visible in the first cycle after accept; each later edge advances one byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            error_code_q       <= ERR_NONE;
            data_shift         <= '0;
            bytes_left         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (check_legal) begin
                            state              <= ST_WRITE;
                            mem_write_enable_q <= 1'b1;
                            mem_address_q      <= bus.req_address;
                            mem_write_data_q   <= bus.req_data[7:0];
                            data_shift         <= {8'h00, bus.req_data[31:8]};
                            bytes_left         <= check_bytes - 3'd1;
                        end else begin
                            state        <= ST_ERROR;
                            error_q      <= 1'b1;
                            error_code_q <= check_code;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bytes_left == 3'd0) begin
                        mem_write_enable_q <= 1'b0;
                        done_q             <= 1'b1;
                        state              <= ST_DONE;
                    end else begin
                        mem_address_q    <= mem_address_q + 32'd1;
                        mem_write_data_q <= data_shift[7:0];
                        data_shift       <= {8'h00, data_shift[31:8]};
                        bytes_left       <= bytes_left - 3'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_ERROR: begin
                    error_q      <= 1'b0;
                    error_code_q <= ERR_NONE;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_store_writer.sv
// Self-checking bench for memory_store_writer: directed and random store
// requests scored cycle by cycle against a behavioural model of the
// width/alignment/range rules and the byte-serial timing.
module tb_memory_store_writer;

    localparam int DEPTH     = 512;
    localparam int CAP_BYTES = 4 * DEPTH;
    localparam int NCYC      = 32;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Expected behaviour per cycle, cycle 0 being the accept edge
    logic        exp_we    [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [7:0]  exp_data  [NCYC];
    logic        exp_done  [NCYC];
    logic        exp_err   [NCYC];
    logic [1:0]  exp_code  [NCYC];
    logic        exp_ready [NCYC];

    always #5 clock = ~clock;

    memory_store_writer_if bus ();

    memory_store_writer #(
        .depth (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reset every expectation to "idle, nothing happening"
    task automatic clear_expect();
        for (int i = 0; i < NCYC; i++) begin
            exp_we[i]    = 1'b0;
            exp_addr[i]  = '0;
            exp_data[i]  = '0;
            exp_done[i]  = 1'b0;
            exp_err[i]   = 1'b0;
            exp_code[i]  = 2'b00;
            exp_ready[i] = 1'b1;
        end
    endtask

    // Reference model: fills expectations for a request accepted at cycle
    // 'start' and returns the cycle in which the block is ready again.
    task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] width, input int start,
                               output int finish);
        longint a;
        int     nbytes;
        int     code;
        a      = longint'(addr);
        nbytes = 0;
        if (width == 2'd3) begin
            code = 3;
        end else begin
            nbytes = 1 << width;
            if (a % nbytes != 0)                   code = 1;
            else if (a + nbytes > longint'(CAP_BYTES)) code = 2;
            else                                   code = 0;
        end
        if (code != 0) begin
            exp_err[start + 1]   = 1'b1;
            exp_code[start + 1]  = 2'(code);
            exp_ready[start + 1] = 1'b0;
            finish = start + 2;
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                exp_we[start + 1 + i]    = 1'b1;
                exp_addr[start + 1 + i]  = addr + 32'(i);
                exp_data[start + 1 + i]  = 8'((data >> (8 * i)) & 32'hFF);
                exp_ready[start + 1 + i] = 1'b0;
            end
            exp_done[start + nbytes + 1]  = 1'b1;
            exp_ready[start + nbytes + 1] = 1'b0;
            finish = start + nbytes + 2;
        end
    endtask

    // Drive one request (optionally chained with a second one while
    // req_valid stays high) and score every cycle until ready returns.
    task automatic run_store(input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] w1,
                             input bit chain,
                             input logic [31:0] a2, input logic [31:0] d2, input logic [1:0] w2,
                             input string name);
        int f1;
        int last;
        @(negedge clock);
        for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wait_ready: req_ready got %b expected 1", name, bus.req_ready);
            return;
        end
        clear_expect();
        model_store(a1, d1, w1, 0, f1);
        last = f1;
        if (chain) model_store(a2, d2, w2, f1, last);
        bus.req_valid   = 1'b1;
        bus.req_address = a1;
        bus.req_data    = d1;
        bus.req_width   = w1;
        @(posedge clock);
        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_write_enable !== exp_we[c]) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d mem_write_enable: got %b expected %b",
                         name, c, bus.mem_write_enable, exp_we[c]);
            end
            if (exp_we[c]) begin
                checks++;
                if (bus.mem_address !== exp_addr[c] || bus.mem_write_data !== exp_data[c]) begin
                    errors++;
                    $display("[TB] FAIL %s cycle %0d write: got %02h@%08h expected %02h@%08h",
                             name, c, bus.mem_write_data, bus.mem_address, exp_data[c], exp_addr[c]);
                end
            end
            checks++;
            if (bus.done !== exp_done[c] || bus.error !== exp_err[c] || bus.error_code !== exp_code[c]) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d status: got done=%b error=%b code=%b expected done=%b error=%b code=%b",
                         name, c, bus.done, bus.error, bus.error_code, exp_done[c], exp_err[c], exp_code[c]);
            end
            checks++;
            if (bus.req_ready !== exp_ready[c]) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d req_ready: got %b expected %b",
                         name, c, bus.req_ready, exp_ready[c]);
            end
            if (chain && c < f1) begin
                bus.req_address = a2;
                bus.req_data    = d2;
                bus.req_width   = w2;
            end else if (!chain || c > f1) begin
                bus.req_valid   = 1'b0;
                bus.req_address = $urandom;
                bus.req_data    = $urandom;
                bus.req_width   = 2'($urandom_range(0, 3));
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.req_width   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.mem_address !== 32'd0 || bus.mem_write_data !== 8'd0 || bus.mem_write_enable !== 1'b0 ||
            bus.done !== 1'b0 || bus.error !== 1'b0 || bus.error_code !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset outputs: got addr=%h data=%h we=%b done=%b error=%b code=%b expected all zero",
                     bus.mem_address, bus.mem_write_data, bus.mem_write_enable, bus.done, bus.error, bus.error_code);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_word_store();
        run_store(32'h10, 32'h11223344, 2'd2, 1'b0, '0, '0, '0, "word_0x10");
    endtask

    task automatic test_error_codes();
        run_store(32'h11, 32'h12345678, 2'd1, 1'b0, '0, '0, '0, "half_misaligned");
        run_store(32'h11, 32'h12345678, 2'd3, 1'b0, '0, '0, '0, "width3_priority");
        run_store(32'h02, 32'hCAFEF00D, 2'd2, 1'b0, '0, '0, '0, "word_misaligned");
    endtask

    task automatic test_range_boundaries();
        run_store(32'h7FC,      32'hA1B2C3D4, 2'd2, 1'b0, '0, '0, '0, "word_top");
        run_store(32'h7FE,      32'h0000BEEF, 2'd1, 1'b0, '0, '0, '0, "half_top");
        run_store(32'h7FF,      32'h000000E7, 2'd0, 1'b0, '0, '0, '0, "byte_top");
        run_store(32'h800,      32'h01020304, 2'd2, 1'b0, '0, '0, '0, "word_past_end");
        run_store(32'h800,      32'h01020304, 2'd0, 1'b0, '0, '0, '0, "byte_past_end");
        run_store(32'hFFFFFFFC, 32'h55667788, 2'd2, 1'b0, '0, '0, '0, "word_no_wrap");
        run_store(32'hFFFFFFFE, 32'h55667788, 2'd1, 1'b0, '0, '0, '0, "half_no_wrap");
    endtask

    task automatic test_byte_store();
        run_store(32'h5, 32'hAABBCCDD, 2'd0, 1'b0, '0, '0, '0, "byte_0x5");
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] d;
        d = $urandom;
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_address = 32'h20;
        bus.req_data    = d;
        bus.req_width   = 2'd2;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_write_enable !== 1'b1 || bus.mem_address !== 32'h20 || bus.mem_write_data !== d[7:0]) begin
            errors++;
            $display("[TB] FAIL reset_mid byte0: got we=%b %02h@%08h expected we=1 %02h@00000020",
                     bus.mem_write_enable, bus.mem_write_data, bus.mem_address, d[7:0]);
        end
        @(negedge clock);
        checks++;
        if (bus.mem_write_enable !== 1'b1 || bus.mem_address !== 32'h21 || bus.mem_write_data !== d[15:8]) begin
            errors++;
            $display("[TB] FAIL reset_mid byte1: got we=%b %02h@%08h expected we=1 %02h@00000021",
                     bus.mem_write_enable, bus.mem_write_data, bus.mem_address, d[15:8]);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.mem_address !== 32'd0 || bus.mem_write_data !== 8'd0 || bus.mem_write_enable !== 1'b0 ||
            bus.done !== 1'b0 || bus.error !== 1'b0 || bus.error_code !== 2'b00 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid outputs: got addr=%h data=%h we=%b done=%b error=%b code=%b ready=%b expected zeros ready=1",
                     bus.mem_address, bus.mem_write_data, bus.mem_write_enable, bus.done, bus.error,
                     bus.error_code, bus.req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_write_enable !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_mid after %0d: got we=%b done=%b error=%b ready=%b expected 0 0 0 1",
                         c, bus.mem_write_enable, bus.done, bus.error, bus.req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  w2;
        logic [31:0] a2;
        for (int k = 0; k < 3; k++) begin
            w2 = 2'($urandom_range(0, 2));
            a2 = 32'($urandom_range(0, CAP_BYTES - 4)) & ~32'h3;
            run_store(32'h100 + 32'(k * 16), $urandom, 2'd2, 1'b1, a2, $urandom, w2, "back_to_back");
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  w;
        int          pick;
        for (int k = 0; k < 24; k++) begin
            w    = 2'($urandom_range(0, 3));
            pick = $urandom_range(0, 3);
            case (pick)
                0:       a = 32'($urandom_range(0, CAP_BYTES - 1)) & ~32'h3;
                1:       a = 32'(CAP_BYTES) - 32'($urandom_range(1, 6));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 63));
            endcase
            run_store(a, $urandom, w, 1'b0, '0, '0, '0, "random");
        end
    endtask

    // Safety net in case the DUT or a task stalls indefinitely
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_word_store();
        test_error_codes();
        test_range_boundaries();
        test_byte_store();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
